// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned NREQ_DEF   = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_t;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write-side bundle for fifo_wr_arbiter; master is the arbiter side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  localparam int unsigned IW = idx_w(NREQ);

  logic [NREQ-1:0]        REQ;
  logic [NREQ*DATA_W-1:0] DIN;
  logic [NREQ-1:0]        ACK;
  logic                   FIFO_WR;
  logic [DATA_W-1:0]      FIFO_DIN;
  logic                   FIFO_FULL;
  logic                   FIFO_OVER;
  logic [IW-1:0]          OWNER;
  logic                   LOCKED;
  logic                   ERR;

  modport master (
    input  REQ, DIN, FIFO_FULL, FIFO_OVER,
    output ACK, FIFO_WR, FIFO_DIN, OWNER, LOCKED, ERR
  );

  modport slave (
    output REQ, DIN, FIFO_FULL, FIFO_OVER,
    input  ACK, FIFO_WR, FIFO_DIN, OWNER, LOCKED, ERR
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-find-first; first set bit of req at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    int unsigned j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (32'(ptr) + off) % N;
      if (!valid && req[W'(j)]) begin
        valid       = 1'b1;
        gnt[W'(j)]  = 1'b1;
        idx         = W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
// Optional burst locking is enabled with the FIFO_ARB_BURST_EN macro.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_LEN = 4
) (
  input logic               CLK,
  input logic               RST,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned IW = idx_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported NREQ or BURST_LEN");
  end

  logic [IW-1:0]     ptr;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_nxt;
  logic [NREQ-1:0]   search;
  logic [NREQ-1:0]   gnt;
  logic              valid;
  logic              grant;
  logic              err;
  logic [DATA_W-1:0] din_sel;

  rr_pick #(
    .N (NREQ),
    .W (IW)
  ) u_pick (
    .req   (search),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (idx),
    .valid (valid)
  );

  // A full FIFO or reset suppresses the grant; pointer and lock state then hold.
  assign grant   = valid & ~bus.FIFO_FULL & ~RST;
  assign idx_nxt = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

  always_comb begin
    din_sel = '0;
    if (grant) din_sel = bus.DIN[idx*DATA_W +: DATA_W];
  end

  assign bus.ACK      = grant ? gnt : '0;
  assign bus.FIFO_WR  = grant;
  assign bus.FIFO_DIN = din_sel;
  assign bus.OWNER    = owner;
  assign bus.ERR      = err;

  always_ff @(posedge CLK) begin
    if (RST) err <= 1'b0;
    else     err <= err | bus.FIFO_OVER;
  end

`ifdef FIFO_ARB_BURST_EN
  arb_state_t    state;
  logic [3:0]    beats;
  logic          locked;
  logic [IW-1:0] owner_nxt;

  assign owner_nxt  = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign bus.LOCKED = locked;

  // While locked only the owner is visible to the picker.
  always_comb begin
    search = bus.REQ;
    if (state == ARB_LOCK) begin
      search        = '0;
      search[owner] = bus.REQ[owner];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB_IDLE;
      ptr    <= '0;
      owner  <= '0;
      locked <= 1'b0;
      beats  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant) begin
            owner <= idx;
            if (BURST_LEN > 1) begin
              state  <= ARB_LOCK;
              locked <= 1'b1;
              beats  <= 4'd1;
            end else begin
              ptr <= idx_nxt;
            end
          end
        end
        ARB_LOCK: begin
          if (!bus.REQ[owner] || (grant && beats == 4'(BURST_LEN - 1))) begin
            state  <= ARB_IDLE;
            locked <= 1'b0;
            beats  <= '0;
            ptr    <= owner_nxt;
          end else if (grant) begin
            beats <= beats + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
`else
  assign search     = bus.REQ;
  assign bus.LOCKED = 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr   <= '0;
      owner <= '0;
    end else if (grant) begin
      ptr   <= idx_nxt;
      owner <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, FIFO fill/stall, burst and error sequences.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(4), .DATA_W(16)) bus ();

  fifo_wr_arbiter #(
    .NREQ      (4),
    .DATA_W    (16),
    .BURST_LEN (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] din;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       over;
    logic [3:0] ack;
    logic [1:0] owner;
    logic       err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [15:0] fq[$];
  logic        obs_wr;
  logic [15:0] obs_din;
  logic [15:0] din_w [4] = '{16'h00A1, 16'h00B1, 16'h00C1, 16'h00D1};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [3:0] a);
    word_of = '0;
    for (int i = 0; i < 4; i++) if (a[i]) word_of = din_w[i];
  endfunction

  // Drive one cycle, queue the expected write, compare mid-cycle, leave just after the edge.
  task automatic step(input logic [3:0] r, input logic f, input logic o, input logic [3:0] ea);
    exp_t e;
    bus.REQ       = r;
    bus.FIFO_FULL = f;
    bus.FIFO_OVER = o;
    e.ack = ea;
    e.din = word_of(ea);
    sb.push_back(e);
    @(negedge clk);
    obs_wr  = bus.FIFO_WR;
    obs_din = bus.FIFO_DIN;
    e = sb.pop_front();
    check("ack", 32'(bus.ACK), 32'(e.ack));
    check("fifo_wr", 32'(bus.FIFO_WR), 32'(|e.ack));
    check("fifo_din", 32'(bus.FIFO_DIN), 32'(e.din));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step(4'b1111, 1'b0, 1'b0, 4'b0000);
    rst = 1'b0;
    check("rst_owner", 32'(bus.OWNER), 0);
    check("rst_locked", 32'(bus.LOCKED), 0);
    check("rst_err", 32'(bus.ERR), 0);
  endtask

`ifndef FIFO_ARB_BURST_EN
  vec_t tbl [13];

  task automatic run_table();
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{4'b0101, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0};
    tbl[3]  = '{4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0};
    tbl[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0};
    tbl[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[9]  = '{4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0};
    tbl[10] = '{4'b0110, 1'b1, 1'b1, 4'b0000, 2'd3, 1'b1};
    tbl[11] = '{4'b0110, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].req, tbl[i].full, tbl[i].over, tbl[i].ack);
      check($sformatf("owner[%0d]", i), 32'(bus.OWNER), 32'(tbl[i].owner));
      check($sformatf("err[%0d]", i), 32'(bus.ERR), 32'(tbl[i].err));
      check($sformatf("locked[%0d]", i), 32'(bus.LOCKED), 0);
    end
  endtask

  // 8-deep FIFO with a registered FULL flag; one read frees a slot at c==10.
  task automatic run_fill();
    int cnt = 0;
    int nw  = 0;
    logic f;
    logic [3:0] ea;
    for (int c = 0; c < 14; c++) begin
      f  = (cnt == 8);
      ea = f ? 4'b0000 : 4'(1 << (nw % 4));
      step(4'b1111, f, 1'b0, ea);
      if (obs_wr) begin
        fq.push_back(obs_din);
        nw++;
        cnt++;
      end
      if (c == 10) begin
        check("fifo_rd0", 32'(fq.pop_front()), 32'h00A1);
        cnt--;
      end
    end
    check("write_count", nw, 9);
    for (int k = 1; k < 9; k++) begin
      if (fq.size() == 0) check("fifo_underrun", 0, 1);
      else check($sformatf("fifo_rd%0d", k), 32'(fq.pop_front()), 32'(word_of(4'(1 << (k % 4)))));
    end
  endtask
`else
  task automatic run_burst();
    for (int b = 0; b < 8; b++) begin
      step(4'b0011, 1'b0, 1'b0, (b < 4) ? 4'b0001 : 4'b0010);
      check($sformatf("burst_locked[%0d]", b), 32'(bus.LOCKED), (b == 3 || b == 7) ? 0 : 1);
      check($sformatf("burst_owner[%0d]", b), 32'(bus.OWNER), (b < 4) ? 0 : 1);
    end
    reset_dut();
    step(4'b0011, 1'b0, 1'b0, 4'b0001);
    step(4'b0011, 1'b1, 1'b0, 4'b0000);
    check("stall_locked", 32'(bus.LOCKED), 1);
    step(4'b0011, 1'b0, 1'b0, 4'b0001);
    step(4'b0010, 1'b0, 1'b0, 4'b0000);
    check("drop_locked", 32'(bus.LOCKED), 0);
    step(4'b0010, 1'b0, 1'b0, 4'b0010);
    check("drop_owner", 32'(bus.OWNER), 1);
    check("drop_relock", 32'(bus.LOCKED), 1);
    reset_dut();
    step(4'b0011, 1'b0, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 1'b0, 4'b0001);
    rst = 1'b1;
    step(4'b0011, 1'b0, 1'b0, 4'b0000);
    rst = 1'b0;
    check("midrst_locked", 32'(bus.LOCKED), 0);
    check("midrst_owner", 32'(bus.OWNER), 0);
    step(4'b0011, 1'b0, 1'b0, 4'b0001);
  endtask
`endif

  initial begin
    bus.DIN       = {din_w[3], din_w[2], din_w[1], din_w[0]};
    bus.REQ       = '0;
    bus.FIFO_FULL = 1'b0;
    bus.FIFO_OVER = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();
`ifndef FIFO_ARB_BURST_EN
    run_table();
    reset_dut();
    run_fill();
`else
    run_burst();
`endif
    reset_dut();
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    check("over_err0", 32'(bus.ERR), 1);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);
    check("over_err1", 32'(bus.ERR), 1);
    step(4'b0001, 1'b0, 1'b0, 4'b0001);
    check("over_err2", 32'(bus.ERR), 1);
    reset_dut();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one 16-bit, 8-deep `fifo` instance among `NREQ` producers. It drives the FIFO write port (`FIFO_WR`, `FIFO_DIN`) and never issues a write while the FIFO reports `FULL`. It optionally locks a grant for bursts. It sits between the producer blocks and the FIFO write side; the read side is not touched.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 16: word width; must match the FIFO.
- `BURST_LEN`, default 4: maximum beats per locked grant, 1..15. Used only with `FIFO_ARB_BURST_EN`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `REQ` in NREQ: per-requester write request. Held with data stable until acked.
- `DIN` in NREQ*DATA_W: packed data; requester i is at [i*DATA_W +: DATA_W].
- `ACK` out NREQ: one-hot, combinational. Bit i high means the word from requester i is written at this edge.
- `FIFO_WR` out 1: FIFO write strobe, combinational; equals |ACK.
- `FIFO_DIN` out DATA_W: the selected requester's data. 0 when no ACK.
- `FIFO_FULL` in 1: `FULL` flag from the FIFO.
- `FIFO_OVER` in 1: `OVER` flag from the FIFO.
- `OWNER` out $clog2(NREQ): registered; index of the last granted requester.
- `LOCKED` out 1: registered; high while a burst lock is held. Always 0 without the macro.
- `ERR` out 1: registered, sticky; set when `FIFO_OVER` is seen; cleared only by `RST`.

## Operation
- Priority pointer `PTR` (registered): the search starts at `PTR` and wraps modulo NREQ. The winner is the first i with REQ[i]=1.
- Grant condition: winner exists and `FIFO_FULL`=0. Then ACK[winner]=1, `FIFO_WR`=1, `FIFO_DIN`=DIN[winner].
- If `FIFO_FULL`=1: ACK=0 and `FIFO_WR`=0. `PTR` and the burst state are unchanged, so the stall keeps fairness.
- After a single-beat grant to i: `PTR` <= (i+1) mod NREQ and `OWNER` <= i.
- State machine:
  - Without the macro: IDLE only.
  - With the macro: IDLE and LOCK, described under Configuration.
- `ERR` <= `ERR` | `FIFO_OVER`. `FIFO_OVER` must never assert in correct operation, because writes are gated by `FIFO_FULL`.
- Requester behaviour:
  - Dropping REQ without an ACK is legal; the request is simply withdrawn.
  - Changing DIN while REQ=1 and no ACK is a protocol violation. No checking is required.

## Timing
- Zero-latency grant: REQ high in cycle t, with `FIFO_FULL`=0 and the requester winning, gives ACK and `FIFO_WR` in cycle t. The FIFO latches the word at the end of cycle t.
- Back-to-back grants are allowed every cycle. `FIFO_FULL` is registered inside the FIFO, so the 8th write is followed by a stall in the next cycle.
- Reset values: `PTR`=0, `OWNER`=0, `LOCKED`=0, `ERR`=0, state IDLE, burst counter 0. While `RST`=1, ACK=0 and `FIFO_WR`=0.
- Reset in the middle of a burst drops the lock immediately. The in-flight word is not acked.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - IDLE to LOCK on a grant to i while REQ[i] stays high; `LOCKED` <= 1 and beat count = 1.
  - In LOCK, only requester i is searched.
  - Each acked beat increments the count. A `FIFO_FULL` stall holds the count and the lock.
  - LOCK to IDLE when REQ[i]=0, or when the beat count reaches `BURST_LEN`. On exit, `PTR` <= (i+1) mod NREQ.
  - `BURST_LEN`=1 is equivalent to the macro being undefined.
- Macro undefined: single-beat round-robin only. `LOCKED` is tied to 0 and there is no counter logic.

## Structure
- Package `fifo_arb_pkg` holds:
  - `DATA_W_DEF`=16 and `NREQ_DEF`=4.
  - The state typedef, `arb_state_t` {ARB_IDLE, ARB_LOCK}.
- Sub-module `rr_pick`: combinational rotate-and-find-first. Inputs are the request vector and `PTR`; outputs are a one-hot grant and the index. It is reused by later read-side schedulers.

## Test plan
- Reset, then REQ=4'b0001 with DIN0=16'h00A1 and FIFO empty: ACK=4'b0001 in the same cycle, `FIFO_DIN`=16'h00A1, then `PTR`=1 and `OWNER`=0.
- REQ=4'b1111 held, no macro: ACK sequence is 0001, 0010, 0100, 1000, 0001 … The FIFO fills after 8 writes, then `FIFO_WR`=0 while `FULL`=1. One FIFO read gives one more ACK, in continuing order.
- REQ=4'b0101 with `PTR`=2: ACK=4'b0100 first, then 4'b0001.
- With the macro, `BURST_LEN`=4, REQ=4'b0011 held: 4 ACKs to requester 0 with `LOCKED`=1, then 4 to requester 1. Dropping REQ[0] after 2 beats hands over to requester 1 in the next cycle.
- Force `FIFO_OVER`=1 for 1 cycle: `ERR`=1 from the next cycle and held until `RST`.
- `RST` pulsed in the middle of a burst (beat 2): the next cycle shows `LOCKED`=0, `PTR`=0, and no ACK.
